// File: rtl/alu_exec_unit_pkg.sv
// Shared integer op types and default widths for the execution units.
package alu_exec_unit_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;
   localparam int unsigned ROB_TAG_W    = 5;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_XOR,
      ALU_OR,
      ALU_AND,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA,
      ALU_SLT,
      ALU_SLTU,
      ALU_LUI,
      ALU_AUIPC,
      ALU_NOALU
   } ALU_operation_t;

endpackage

// File: rtl/alu_core.sv
// Combinational integer ALU: (op, a, b, pc) -> result. Shared with the branch unit.
module alu_core
   import alu_exec_unit_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  ALU_operation_t  op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] result_c
);

   localparam int unsigned SHAMT_W = 5;

   logic [SHAMT_W-1:0] shamt;

   assign shamt = b[SHAMT_W-1:0];

   always_comb begin
      result_c = '0;
      case (op)
         ALU_ADD:   result_c = a + b;
         ALU_SUB:   result_c = a - b;
         ALU_XOR:   result_c = a ^ b;
         ALU_OR:    result_c = a | b;
         ALU_AND:   result_c = a & b;
         ALU_SLL:   result_c = a << shamt;
         ALU_SRL:   result_c = a >> shamt;
         ALU_SRA:   result_c = XLEN'($signed(a) >>> shamt);
         ALU_SLT:   result_c = XLEN'($signed(a) < $signed(b));
         ALU_SLTU:  result_c = XLEN'(a < b);
         ALU_LUI:   result_c = b;
         ALU_AUIPC: result_c = pc + b;
         default:   result_c = '0;
      endcase
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Two-stage ALU functional unit (E1 operand latch, E2 result) with CDB
// valid/grant backpressure and single-cycle flush.
module alu_exec_unit
   import alu_exec_unit_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEFAULT,
   parameter int unsigned TAG_W = ROB_TAG_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             issue_valid,
   output logic             issue_ready,
   input  ALU_operation_t   issue_op,
   input  logic [XLEN-1:0]  issue_a,
   input  logic [XLEN-1:0]  issue_b,
   input  logic [XLEN-1:0]  issue_pc,
   input  logic [TAG_W-1:0] issue_tag,
   input  logic             flush,
   output logic             cdb_valid,
   input  logic             cdb_grant,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [XLEN-1:0]  cdb_result
);

   logic             e1_valid;
   ALU_operation_t   e1_op;
   logic [XLEN-1:0]  e1_a;
   logic [XLEN-1:0]  e1_b;
   logic [XLEN-1:0]  e1_pc;
   logic [TAG_W-1:0] e1_tag;
   logic             e2_valid;
   logic             e1_adv;
   logic             e2_adv;
   logic             issue_fire;
   logic [XLEN-1:0]  core_result;

   // A stage may advance when empty or when its downstream consumer frees up.
   assign e2_adv      = !e2_valid || cdb_grant;
   assign e1_adv      = !e1_valid || e2_adv;
   assign issue_ready = e1_adv && !flush;
   assign issue_fire  = issue_valid && issue_ready;
   assign cdb_valid   = e2_valid;

   alu_core #(.XLEN(XLEN)) u_alu_core (
      .op       (e1_op),
      .a        (e1_a),
      .b        (e1_b),
      .pc       (e1_pc),
      .result_c (core_result)
   );

   // Flush dominates accept, advance and grant; E2 payload only moves on advance
   // so cdb_tag/cdb_result hold while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e1_valid   <= 1'b0;
         e2_valid   <= 1'b0;
         e1_op      <= ALU_NOALU;
         e1_a       <= '0;
         e1_b       <= '0;
         e1_pc      <= '0;
         e1_tag     <= '0;
         cdb_tag    <= '0;
         cdb_result <= '0;
      end else if (flush) begin
         e1_valid <= 1'b0;
         e2_valid <= 1'b0;
      end else begin
         if (e1_adv) begin
            e1_valid <= issue_valid;
         end
         if (issue_fire) begin
            e1_op  <= issue_op;
            e1_a   <= issue_a;
            e1_b   <= issue_b;
            e1_pc  <= issue_pc;
            e1_tag <= issue_tag;
         end
         if (e2_adv) begin
            e2_valid <= e1_valid;
         end
         if (e1_valid && e2_adv) begin
            cdb_tag    <= e1_tag;
            cdb_result <= core_result;
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a queue-based reference model.
module tb_alu_exec_unit;
   import alu_exec_unit_pkg::*;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned TAG_W = 5;

   logic             clk;
   logic             rst_n;
   logic             issue_valid;
   logic             issue_ready;
   ALU_operation_t   issue_op;
   logic [XLEN-1:0]  issue_a;
   logic [XLEN-1:0]  issue_b;
   logic [XLEN-1:0]  issue_pc;
   logic [TAG_W-1:0] issue_tag;
   logic             flush;
   logic             cdb_valid;
   logic             cdb_grant;
   logic [TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]  cdb_result;

   alu_exec_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_op    (issue_op),
      .issue_a     (issue_a),
      .issue_b     (issue_b),
      .issue_pc    (issue_pc),
      .issue_tag   (issue_tag),
      .flush       (flush),
      .cdb_valid   (cdb_valid),
      .cdb_grant   (cdb_grant),
      .cdb_tag     (cdb_tag),
      .cdb_result  (cdb_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference semantics written from the operation definitions.
   function automatic logic [31:0] model(input ALU_operation_t op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] pc);
      logic [63:0] ext;
      int sh;
      sh = int'(b[4:0]);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a + ~b + 32'd1;
         ALU_XOR:   return a ^ b;
         ALU_OR:    return a | b;
         ALU_AND:   return a & b;
         ALU_SLL:   return a << sh;
         ALU_SRL:   return a >> sh;
         ALU_SRA: begin
            ext = {{32{a[31]}}, a} >> sh;
            return ext[31:0];
         end
         ALU_SLT:   return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
         ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         ALU_LUI:   return b;
         ALU_AUIPC: return pc + b;
         default:   return 32'd0;
      endcase
   endfunction

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      res;
   } exp_t;

   exp_t             exp_q[$];
   exp_t             e;
   logic [31:0]      got_res[$];
   logic [TAG_W-1:0] got_tag[$];
   int               got_cyc[$];
   int               cyc = 0;
   logic             hold_v = 1'b0;
   logic [TAG_W-1:0] hold_tag;
   logic [31:0]      hold_res;

   always @(negedge rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
   end

   // Compare process: inputs change just after posedge, so mid-cycle values
   // are exactly what the next rising edge will act on.
   always @(negedge clk) begin
      cyc++;
      if (!rst_n) begin
         exp_q.delete();
         hold_v = 1'b0;
      end else begin
         if (hold_v && cdb_valid) begin
            chk("hold_tag", 32'(cdb_tag), 32'(hold_tag));
            chk("hold_result", cdb_result, hold_res);
         end
         if (cdb_valid && cdb_grant) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_broadcast", 32'(cdb_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
               chk("cdb_result", cdb_result, e.res);
            end
            got_res.push_back(cdb_result);
            got_tag.push_back(cdb_tag);
            got_cyc.push_back(cyc);
         end
         if (flush) exp_q.delete();
         if (issue_valid && issue_ready)
            exp_q.push_back('{tag: issue_tag, res: model(issue_op, issue_a, issue_b, issue_pc)});
         hold_v   = cdb_valid && !cdb_grant;
         hold_tag = cdb_tag;
         hold_res = cdb_result;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input ALU_operation_t op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] pc, input logic [TAG_W-1:0] tag);
      issue_op    = op;
      issue_a     = a;
      issue_b     = b;
      issue_pc    = pc;
      issue_tag   = tag;
      issue_valid = 1'b1;
   endtask

   // Offer an op until accepted (bounded); returns just after the accepting edge.
   task automatic send(input ALU_operation_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [TAG_W-1:0] tag);
      logic acc;
      acc = 1'b0;
      set_op(op, a, b, pc, tag);
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = issue_ready;
         step();
      end
      if (!acc) chk("send_timeout", 32'(acc), 32'd1);
      issue_valid = 1'b0;
   endtask

   task automatic chk_log(input string name, input int idx, input logic [31:0] res,
                          input logic [TAG_W-1:0] tag);
      if (idx < got_res.size()) begin
         chk({name, "_result"}, got_res[idx], res);
         chk({name, "_tag"}, 32'(got_tag[idx]), 32'(tag));
      end else begin
         chk({name, "_missing"}, 32'(got_res.size()), 32'(idx + 1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   int base;

   initial begin
      rst_n       = 1'b0;
      issue_valid = 1'b0;
      issue_op    = ALU_ADD;
      issue_a     = '0;
      issue_b     = '0;
      issue_pc    = '0;
      issue_tag   = '0;
      flush       = 1'b0;
      cdb_grant   = 1'b1;

      // Reset state
      #12;
      chk("rst_cdb_valid", 32'(cdb_valid), 32'd0);
      chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
      chk("rst_cdb_result", cdb_result, 32'd0);
      step();
      rst_n = 1'b1;
      #1;
      chk("rst_issue_ready", 32'(issue_ready), 32'd1);

      // Single add: two-edge latency
      send(ALU_ADD, 32'd5, 32'd7, 32'd0, 5'd3);
      @(negedge clk);
      chk("lat_not_yet_valid", 32'(cdb_valid), 32'd0);
      chk("lat_issue_ready", 32'(issue_ready), 32'd1);
      @(negedge clk);
      chk("lat_valid", 32'(cdb_valid), 32'd1);
      chk("add_result", cdb_result, 32'd12);
      chk("add_tag", 32'(cdb_tag), 32'd3);
      step();
      step();

      // Back-to-back with continuous grant
      base = got_res.size();
      send(ALU_SUB, 32'd3, 32'd5, 32'd0, 5'd4);
      send(ALU_SRA, 32'h8000_0000, 32'd4, 32'd0, 5'd5);
      send(ALU_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 5'd6);
      send(ALU_AUIPC, 32'd0, 32'h2000, 32'h1000, 5'd7);
      repeat (4) step();
      chk("b2b_count", 32'(got_res.size() - base), 32'd4);
      chk_log("b2b_sub", base, 32'hFFFF_FFFE, 5'd4);
      chk_log("b2b_sra", base + 1, 32'hF800_0000, 5'd5);
      chk_log("b2b_sltu", base + 2, 32'd1, 5'd6);
      chk_log("b2b_auipc", base + 3, 32'h3000, 5'd7);
      if (got_res.size() >= base + 4)
         for (int i = 1; i < 4; i++)
            chk("b2b_spacing", 32'(got_cyc[base + i] - got_cyc[base + i - 1]), 32'd1);

      // Backpressure: grant low, three ops offered
      base = got_res.size();
      cdb_grant = 1'b0;
      send(ALU_SLL, 32'd1, 32'd4, 32'd0, 5'd10);
      send(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 5'd11);
      set_op(ALU_OR, 32'h100, 32'h001, 32'd0, 5'd12);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_issue_ready", 32'(issue_ready), 32'd0);
         chk("stall_cdb_valid", 32'(cdb_valid), 32'd1);
         chk("stall_cdb_result", cdb_result, 32'h10);
         step();
      end
      cdb_grant = 1'b1;
      send(ALU_OR, 32'h100, 32'h001, 32'd0, 5'd12);
      repeat (4) step();
      chk("bp_count", 32'(got_res.size() - base), 32'd3);
      chk_log("bp_sll", base, 32'h10, 5'd10);
      chk_log("bp_xor", base + 1, 32'h0000_FF00, 5'd11);
      chk_log("bp_or", base + 2, 32'h101, 5'd12);

      // Flush with two ops in flight and a concurrent issue
      cdb_grant = 1'b0;
      send(ALU_AND, 32'hFF, 32'h0F, 32'd0, 5'd1);
      send(ALU_SRL, 32'h80, 32'd3, 32'd0, 5'd2);
      set_op(ALU_ADD, 32'd1, 32'd1, 32'd0, 5'd4);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_issue_ready", 32'(issue_ready), 32'd0);
      step();
      flush = 1'b0;
      issue_valid = 1'b0;
      @(negedge clk);
      chk("flush_cdb_valid", 32'(cdb_valid), 32'd0);
      step();
      cdb_grant = 1'b1;
      base = got_res.size();
      send(ALU_LUI, 32'd0, 32'h1234_5000, 32'd0, 5'd6);
      repeat (4) step();
      chk("post_flush_count", 32'(got_res.size() - base), 32'd1);
      chk_log("post_flush_lui", base, 32'h1234_5000, 5'd6);

      // Asynchronous reset while a result is being held
      cdb_grant = 1'b0;
      send(ALU_ADD, 32'h11, 32'h22, 32'd0, 5'd13);
      step();
      @(negedge clk);
      chk("pre_rst_valid", 32'(cdb_valid), 32'd1);
      chk("pre_rst_result", cdb_result, 32'h33);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(cdb_valid), 32'd0);
      chk("async_rst_tag", 32'(cdb_tag), 32'd0);
      chk("async_rst_result", cdb_result, 32'd0);
      step();
      rst_n = 1'b1;
      cdb_grant = 1'b1;
      step();

      // noALU still broadcasts; signed compare pins
      base = got_res.size();
      send(ALU_NOALU, 32'h55, 32'h66, 32'd0, 5'd9);
      send(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd14);
      send(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd15);
      send(ALU_SRA, 32'h4000_0000, 32'd33, 32'd0, 5'd16);
      repeat (4) step();
      chk("tail_count", 32'(got_res.size() - base), 32'd4);
      chk_log("noalu", base, 32'd0, 5'd9);
      chk_log("slt_neg", base + 1, 32'd1, 5'd14);
      chk_log("sltu_big", base + 2, 32'd0, 5'd15);
      chk_log("sra_pos", base + 3, 32'h2000_0000, 5'd16);

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Out-of-order integer ALU functional unit that consumes the `ALU_operation_t` produced by ALU control decode plus operands from the reservation station. It executes in a two-stage registered pipeline (E1 operand latch, E2 result register) and broadcasts the tagged result on the common data bus (CDB) under a valid/grant handshake. It supports full backpressure from CDB arbitration and a single-cycle pipeline flush on mispredict or exception.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `TAG_W`, 5: ROB tag width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `issue_valid`  in  1  reservation station presents an op.
- `issue_ready`  out  1  unit accepts the op this cycle.
- `issue_op`  in  `ALU_operation_t`  operation select.
- `issue_a`  in  XLEN  operand A (rs1).
- `issue_b`  in  XLEN  operand B (rs2 or immediate; U-type immediate already shifted).
- `issue_pc`  in  XLEN  instruction PC, used by AUIPC.
- `issue_tag`  in  TAG_W  destination ROB tag.
- `flush`  in  1  kill all in-flight ops.
- `cdb_valid`  out  1  result available for broadcast.
- `cdb_grant`  in  1  CDB arbiter accepts the broadcast this cycle.
- `cdb_tag`  out  TAG_W  ROB tag of the result.
- `cdb_result`  out  XLEN  result value.

## Operation
Operation semantics:
- add: a+b. sub: a−b. xor, or, and: bitwise.
- sll, srl: logical shifts of a by b[4:0]. sra: arithmetic shift of a by b[4:0].
- slt: {0…, $signed(a)<$signed(b)}. sltu: the same comparison, unsigned.
- lui: b. auipc: pc+b.
- noALU: result 0. The op is still broadcast so its ROB entry completes.
- All arithmetic is mod 2^XLEN. Overflow is ignored.

Pipeline state:
- `e1_valid`, with E1 latched op, a, b, pc and tag.
- `e2_valid`, with E2 latched tag and computed result.
- The result is computed combinationally from E1 and registered into E2.

Flow rules:
- `e2_adv = !e2_valid || cdb_grant`.
- `e1_adv = !e1_valid || e2_adv`.
- `issue_ready = e1_adv && !flush`.
- Accept on `issue_valid && issue_ready`.
- E1 moves into E2 when `e1_valid && e2_adv`. An E2 slot emptied by grant with nothing arriving clears `e2_valid`.

Handshake and flush:
- `cdb_valid = e2_valid`.
- `cdb_tag` and `cdb_result` hold stable while `cdb_valid && !cdb_grant`.
- `cdb_grant` while `!cdb_valid` is ignored.
- `flush` clears `e1_valid` and `e2_valid` at the next edge. It wins over every simultaneous accept, advance and grant.
- A grant coinciding with flush still counts as delivered. The ROB discards it.

## Timing
- Reset: `e1_valid`=0, `e2_valid`=0, `cdb_valid`=0, `cdb_tag`=0, `cdb_result`=0. `issue_ready`=1 once `rst_n` deasserts, unless `flush` is asserted.
- Latency: op accepted at edge T shows `cdb_valid` in the cycle after edge T+1, i.e. two edges.
- Throughput: one op per cycle with continuous grant.
- Stall: the first stall cycle with E1 and E2 both full drops `issue_ready` in that cycle. A grant in that cycle keeps `issue_ready`=1, since E2 drains while E1 refills.
- Mid-operation reset: all valids clear asynchronously and no partial broadcast occurs.
- Data registers without valid may keep stale contents, except `cdb_tag` and `cdb_result`, which reset to 0.

## Structure
- `ALU_operation_t` comes from the shared op-types package; it is not redefined here.
- Add `XLEN_DEFAULT` and `ROB_TAG_W` constants to that package.
- One sub-module, `alu_core`: purely combinational (op, a, b, pc) → result. It is reused by the branch unit.
- The pipeline and handshake stay in `alu_exec_unit`.

## Test plan
- Reset, then issue add a=5 b=7 tag=3 with grant tied high → `cdb_valid` two edges later, result 12, tag 3. `issue_ready` stays 1.
- Back-to-back: sub 3−5 → 0xFFFFFFFE; sra 0x80000000 by 4 → 0xF8000000; sltu 1<0xFFFFFFFF → 1; auipc pc=0x1000 b=0x2000 → 0x3000. Expect one result per cycle, in order.
- Hold `cdb_grant`=0 with three ops offered → two accepted, `issue_ready` drops, `cdb_result` stable. Release grant → remaining results in order, no loss or duplication.
- Two ops in flight, assert `flush` together with `issue_valid` → no accept that cycle, `cdb_valid`=0 next cycle, a fresh op afterward completes normally.
- Assert `rst_n`=0 asynchronously between edges while `cdb_valid`=1 → `cdb_valid`, `cdb_tag` and `cdb_result` go to 0 immediately.
- noALU op tag=9 → broadcast with result 0, tag 9.
